wb_bram_pipe: RTL and testbench
===============================

WB_BRAM_PIPE -- requirements
Module: wb_bram_pipe

Interface
REQ-001 SHALL have parameter BRAM_ADDR_W, default 14, word-address width of the block RAM.
REQ-002 SHALL have parameter DEPTH, default 2**BRAM_ADDR_W, number of populated words, 1..2**BRAM_ADDR_W.
REQ-003 SHALL have parameter READ_LAT, default 1, block RAM read latency in cycles, legal values 1 and 2.
REQ-004 SHALL have parameter CLEAR_ON_RESET, default 1, when 1 zero-fill all DEPTH words after reset.
REQ-005 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port bram_addr  output  BRAM_ADDR_W  block RAM word address.
REQ-008 SHALL have port bram_data_w  output  word_t (32)  block RAM write data.
REQ-009 SHALL have port bram_data_r  input  word_t (32)  block RAM read data.
REQ-010 SHALL have port bram_en  output  1  block RAM port enable.
REQ-011 SHALL have port bram_sel  output  bsel_t (4)  block RAM byte write enables.
REQ-012 SHALL have port bram_regce  output  1  output-register clock enable, used only when READ_LAT=2, else constant 0.
REQ-013 SHALL have port wb  wishbone.slave  -  pipelined Wishbone slave (cyc, stb, we, adr byte address, sel, dat_w, dat_r, ack, err, stall).

Function
REQ-014 SHALL implement states INIT and RUN; after reset go to INIT when CLEAR_ON_RESET=1, else RUN.
REQ-015 In INIT, each cycle: bram_en=1, bram_sel=4'hF, bram_data_w=0, bram_addr=clear counter; counter starts at 0, increments by 1.
REQ-016 SHALL leave INIT for RUN the cycle after the write of word DEPTH-1; INIT lasts exactly DEPTH cycles.
REQ-017 In INIT, wb.stall SHALL be 1 and wb.ack/wb.err SHALL be 0; in RUN, wb.stall SHALL be 0.
REQ-018 A request is accepted in a RUN cycle with wb.cyc=1, wb.stb=1, wb.stall=0; word index = wb.adr[BRAM_ADDR_W+1:2].
REQ-019 Accepted request with index < DEPTH and all wb.adr bits above BRAM_ADDR_W+1 zero is in-range: bram_en=1, bram_addr=index, bram_data_w=wb.dat_w, bram_sel=wb.sel when wb.we else 0.
REQ-020 Out-of-range accepted request: bram_en=0, bram_sel=0; no RAM side effect.
REQ-021 In RUN with no accepted request, bram_en=0 and bram_sel=0.
REQ-022 SHALL track each accepted request in a READ_LAT-stage valid/error shift pipeline; back-to-back acceptance every cycle supported.
REQ-023 Request accepted in cycle t SHALL produce exactly one response in cycle t+READ_LAT: wb.ack=1 if in-range, wb.err=1 if out-of-range, never both.
REQ-024 Writes SHALL respond at the same latency as reads; responses in acceptance order.
REQ-025 wb.dat_r SHALL equal bram_data_r in a read-ack cycle; value unconstrained otherwise.
REQ-026 READ_LAT=2: bram_regce SHALL be 1 in the cycle after an in-range read acceptance, else 0.
REQ-027 wb.cyc=0 SHALL clear all pipeline stages in that cycle; no ack/err for abandoned requests; completed writes stay committed.
REQ-028 wb.stb=1 with wb.cyc=0 SHALL be ignored.

Reset
REQ-029 rst_n=0 SHALL asynchronously force: ack=0, err=0, pipeline empty, clear counter 0, bram_en=0, bram_sel=0, bram_regce=0, state INIT (CLEAR_ON_RESET=1) or RUN (=0); stall=1 while in reset when CLEAR_ON_RESET=1.
REQ-030 Reset mid-INIT or with requests in flight SHALL discard them without response and restart from REQ-014 after rst_n rises.

Verification
REQ-031 DEPTH=16, CLEAR_ON_RESET=1, release rst_n -> stall=1 for 16 cycles, bram writes 0 to addresses 0..15 with sel=4'hF, stall=0 on cycle 17.
REQ-032 READ_LAT=1: write 32'hDEADBEEF sel 4'hF adr 0x10, then read adr 0x10 next cycle -> acks in consecutive cycles, second with dat_r=32'hDEADBEEF.
REQ-033 READ_LAT=2: four back-to-back reads adr 0x0,0x4,0x8,0xC -> four consecutive acks starting 2 cycles after the first acceptance, bram_regce high one cycle after each.
REQ-034 DEPTH=12, BRAM_ADDR_W=4: access adr 0x30 (index 12) between two valid reads -> bram_en=0 that cycle, response sequence ack, err, ack.
REQ-035 Accept two reads (READ_LAT=2), drop cyc the next cycle -> no ack/err ever issued for them.
REQ-036 Pulse rst_n low during INIT at counter 7 -> counter restarts at 0, full DEPTH-cycle clear repeats.

Source files
------------

// File: rtl/wb_bram_pipe_if.sv
// wb_bram_pipe_if: shared word/byte-select types and the pipelined Wishbone bus
package wb_bram_pkg;
  typedef logic [31:0] word_t;
  typedef logic [3:0] bsel_t;
endpackage

interface wishbone;
  import wb_bram_pkg::*;
  logic cyc;
  logic stb;
  logic we;
  logic [31:0] adr;
  bsel_t sel;
  word_t dat_w;
  word_t dat_r;
  logic ack;
  logic err;
  logic stall;
  modport slave (input cyc, stb, we, adr, sel, dat_w, output dat_r, ack, err, stall);
  modport master (output cyc, stb, we, adr, sel, dat_w, input dat_r, ack, err, stall);
endinterface

// File: rtl/wb_bram_pipe.sv
// wb_bram_pipe: pipelined Wishbone slave front-end for a block RAM with optional power-on clear
module wb_bram_pipe
  import wb_bram_pkg::*;
#(
  parameter int BRAM_ADDR_W = 14,
  parameter int DEPTH = 2**BRAM_ADDR_W,
  parameter int READ_LAT = 1,
  parameter bit CLEAR_ON_RESET = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [BRAM_ADDR_W-1:0] bram_addr,
  output word_t                  bram_data_w,
  input  word_t                  bram_data_r,
  output logic                   bram_en,
  output bsel_t                  bram_sel,
  output logic                   bram_regce,
  wishbone.slave                 wb
);
  typedef enum logic {INIT, RUN} state_t;
  localparam logic [BRAM_ADDR_W-1:0] LAST = BRAM_ADDR_W'(DEPTH - 1);
  localparam state_t RST_STATE = CLEAR_ON_RESET ? INIT : RUN;
  state_t state_q, state_d;
  logic [BRAM_ADDR_W-1:0] cnt_q, cnt_d, idx;
  logic [READ_LAT-1:0] vld_q, vld_d, err_q, err_d;
  logic rd_q, rd_d, acc, in_rng;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= RST_STATE;
    else state_q <= state_d;
  // leave INIT once the last populated word has been cleared
  always_comb
    state_d = (state_q == INIT && cnt_q == LAST) ? RUN : state_q;
  // request decode, clear counter advance and response pipeline shift (dropping cyc flushes it)
  always_comb begin
    idx = wb.adr[BRAM_ADDR_W+1:2];
    acc = state_q == RUN && wb.cyc && wb.stb;
    in_rng = (wb.adr >> (BRAM_ADDR_W + 2)) == 32'd0 && 32'(idx) < 32'(DEPTH);
    cnt_d = (state_q == INIT && cnt_q != LAST) ? cnt_q + 1'b1 : '0;
    vld_d = wb.cyc ? (vld_q << 1) | READ_LAT'(acc) : '0;
    err_d = wb.cyc ? (err_q << 1) | READ_LAT'(acc && !in_rng) : '0;
    rd_d = acc && in_rng && !wb.we;
  end
  // clear counter and response pipeline registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      vld_q <= '0;
      err_q <= '0;
      rd_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      vld_q <= vld_d;
      err_q <= err_d;
      rd_q <= rd_d;
    end
  // RAM port drive (zero-fill in INIT, pass-through in RUN) and Wishbone responses
  always_comb begin
    bram_en = rst_n && (state_q == INIT || (acc && in_rng));
    bram_sel = !rst_n ? '0 : state_q == INIT ? 4'hF : (acc && in_rng && wb.we) ? wb.sel : '0;
    bram_addr = state_q == INIT ? cnt_q : idx;
    bram_data_w = state_q == INIT ? '0 : wb.dat_w;
    bram_regce = (READ_LAT == 2) && rd_q;
    wb.stall = state_q != RUN;
    wb.ack = wb.cyc && vld_q[READ_LAT-1] && !err_q[READ_LAT-1];
    wb.err = wb.cyc && err_q[READ_LAT-1];
    wb.dat_r = bram_data_r;
  end
endmodule

// File: tb/tb_wb_bram_pipe.sv
// tb_wb_bram_pipe: scoreboard bench driving two configurations (lat 2/depth 12, lat 1/depth 16) in lockstep
module tb_wb_bram_pipe;
  import wb_bram_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  wishbone wb_a ();
  wishbone wb_b ();
  assign wb_b.cyc = wb_a.cyc;
  assign wb_b.stb = wb_a.stb;
  assign wb_b.we = wb_a.we;
  assign wb_b.adr = wb_a.adr;
  assign wb_b.sel = wb_a.sel;
  assign wb_b.dat_w = wb_a.dat_w;
  logic [3:0] addr_a, addr_b;
  word_t dw_a, dw_b, dr_a, dr_b, rd1_a;
  logic en_a, en_b, regce_a, regce_b;
  bsel_t sel_a, sel_b;
  word_t mem_a [16];
  word_t mem_b [16];
  word_t shadow [2][16];
  wb_bram_pipe #(.BRAM_ADDR_W(4), .DEPTH(12), .READ_LAT(2), .CLEAR_ON_RESET(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bram_addr(addr_a), .bram_data_w(dw_a), .bram_data_r(dr_a),
    .bram_en(en_a), .bram_sel(sel_a), .bram_regce(regce_a), .wb(wb_a));
  wb_bram_pipe #(.BRAM_ADDR_W(4), .DEPTH(16), .READ_LAT(1), .CLEAR_ON_RESET(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bram_addr(addr_b), .bram_data_w(dw_b), .bram_data_r(dr_b),
    .bram_en(en_b), .bram_sel(sel_b), .bram_regce(regce_b), .wb(wb_b));
  // behavioural block RAMs: read-first, A has an output register gated by regce
  always @(posedge clk) begin
    if (en_a) begin
      for (int b = 0; b < 4; b++) if (sel_a[b]) mem_a[addr_a][8*b+:8] <= dw_a[8*b+:8];
      rd1_a <= mem_a[addr_a];
    end
    if (regce_a) dr_a <= rd1_a;
    if (en_b) begin
      for (int b = 0; b < 4; b++) if (sel_b[b]) mem_b[addr_b][8*b+:8] <= dw_b[8*b+:8];
      dr_b <= mem_b[addr_b];
    end
  end
  typedef struct {int k; int due; bit err; bit rd; word_t d;} exp_t;
  exp_t q[$];
  int n_chk = 0;
  int n_err = 0;
  int cyc_n = 0;
  int init_left [2];
  bit prev_rd = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc_n);
    end
  endtask
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    wb_a.cyc = 1'b0;
    wb_a.stb = 1'b0;
    #1;
    q.delete();
    prev_rd = 0;
    init_left[0] = 0;
    init_left[1] = 0;
    for (int k = 0; k < 2; k++) for (int j = 0; j < 16; j++) shadow[k][j] = '0;
    repeat (n) begin
      @(negedge clk);
      check("rst_stall_a", wb_a.stall, 1);
      check("rst_stall_b", wb_b.stall, 1);
      check("rst_en", {en_a, en_b}, 0);
      check("rst_sel", {sel_a, sel_b}, 0);
      check("rst_resp", {wb_a.ack, wb_a.err, wb_b.ack, wb_b.err}, 0);
      check("rst_regce", regce_a, 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    init_left[0] = 12;
    init_left[1] = 16;
  endtask
  task automatic tick(input logic c, input logic s, input logic w, input logic [31:0] a, input bsel_t sl, input word_t d);
    logic [3:0] idx;
    logic acc, inr;
    bit rd_now;
    int f, dep, lat;
    wb_a.cyc = c;
    wb_a.stb = s;
    wb_a.we = w;
    wb_a.adr = a;
    wb_a.sel = sl;
    wb_a.dat_w = d;
    @(negedge clk);
    idx = a[5:2];
    acc = c && s;
    rd_now = 0;
    for (int k = 0; k < 2; k++) begin
      logic st, en, ack, er;
      logic [3:0] ad;
      bsel_t se;
      word_t dw, dr;
      st = k ? wb_b.stall : wb_a.stall;
      en = k ? en_b : en_a;
      ack = k ? wb_b.ack : wb_a.ack;
      er = k ? wb_b.err : wb_a.err;
      ad = k ? addr_b : addr_a;
      se = k ? sel_b : sel_a;
      dw = k ? dw_b : dw_a;
      dr = k ? wb_b.dat_r : wb_a.dat_r;
      dep = k ? 16 : 12;
      lat = k ? 1 : 2;
      check("stall", st, init_left[k] != 0);
      if (init_left[k] != 0) begin
        check("init_en", en, 1);
        check("init_addr", ad, dep - init_left[k]);
        check("init_sel", se, 4'hF);
        check("init_data", dw, 0);
      end else begin
        inr = acc && a[31:6] == 26'd0 && 32'(idx) < dep;
        check("en", en, inr);
        check("sel", se, (inr && w) ? sl : 4'h0);
        if (inr) check("addr", ad, idx);
        if (inr && w) check("data_w", dw, d);
        if (inr && w) for (int b = 0; b < 4; b++) if (sl[b]) shadow[k][idx][8*b+:8] = d[8*b+:8];
        if (acc) q.push_back('{k, cyc_n + lat, !inr, inr && !w, shadow[k][idx]});
        if (k == 0) rd_now = inr && !w;
      end
      if (!c) for (int i = q.size() - 1; i >= 0; i--) if (q[i].k == k) q.delete(i);
      f = -1;
      for (int i = 0; i < q.size(); i++) if (f < 0 && q[i].k == k) f = i;
      if (f >= 0 && q[f].due == cyc_n) begin
        check("ack", ack, !q[f].err);
        check("err", er, q[f].err);
        if (q[f].rd) check("dat_r", dr, q[f].d);
        q.delete(f);
      end else begin
        check("ack_idle", ack, 0);
        check("err_idle", er, 0);
      end
    end
    check("regce_a", regce_a, prev_rd);
    check("regce_b", regce_b, 0);
    prev_rd = rd_now;
    @(posedge clk);
    #1;
    cyc_n++;
    for (int k = 0; k < 2; k++) if (init_left[k] != 0) init_left[k]--;
  endtask
  initial begin
    for (int j = 0; j < 16; j++) begin
      mem_a[j] = 32'hA5A5_0000 + j;
      mem_b[j] = 32'h5A5A_0000 + j;
    end
    wb_a.we = 1'b0;
    wb_a.adr = '0;
    wb_a.sel = '0;
    wb_a.dat_w = '0;
    do_reset(3);
    repeat (7) tick(0, 0, 0, 0, 0, 0);
    do_reset(2);
    repeat (17) tick(1, 0, 0, 0, 0, 0);
    tick(1, 1, 1, 32'h10, 4'hF, 32'hDEADBEEF);
    tick(1, 1, 0, 32'h10, 4'h0, 0);
    repeat (3) tick(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(1, 1, 1, 32'(i * 4), (i == 3) ? 4'b0101 : 4'hF, 32'h1111_1111 * (i + 1));
    for (int i = 0; i < 4; i++) tick(1, 1, 0, 32'(i * 4), 4'h0, 0);
    tick(1, 1, 0, 32'h14, 4'h0, 0);
    repeat (3) tick(1, 0, 0, 0, 0, 0);
    tick(1, 1, 0, 32'h4, 4'h0, 0);
    tick(1, 1, 0, 32'h30, 4'h0, 0);
    tick(1, 1, 0, 32'h8, 4'h0, 0);
    tick(1, 1, 1, 32'h100, 4'hF, 32'h0BAD_0BAD);
    repeat (3) tick(1, 0, 0, 0, 0, 0);
    tick(0, 1, 1, 32'h14, 4'hF, 32'hFFFF_FFFF);
    tick(1, 1, 0, 32'h0, 4'h0, 0);
    tick(1, 1, 0, 32'h4, 4'h0, 0);
    tick(0, 0, 0, 0, 0, 0);
    repeat (4) tick(1, 0, 0, 0, 0, 0);
    tick(1, 1, 0, 32'h14, 4'h0, 0);
    repeat (3) tick(1, 0, 0, 0, 0, 0);
    repeat (300) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? (32'h40 << $urandom_range(0, 20)) : 32'($urandom_range(0, 63));
      tick($urandom_range(0, 15) != 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a, 4'($urandom), $urandom);
    end
    repeat (4) tick(1, 0, 0, 0, 0, 0);
    check("drain", q.size(), 0);
    tick(1, 1, 0, 32'h10, 4'h0, 0);
    tick(1, 1, 0, 32'h14, 4'h0, 0);
    do_reset(2);
    repeat (17) tick(1, 0, 0, 0, 0, 0);
    tick(1, 1, 0, 32'h10, 4'h0, 0);
    repeat (3) tick(1, 0, 0, 0, 0, 0);
    check("drain_end", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
